// File: rtl/parafuzz_pkg.sv
// Shared definitions for the commit-stream comparator: marker instruction,
// comparator FSM state encoding and probe-record packing.
package parafuzz_pkg;

    // Instruction both harnesses retire to mark the end of the test program.
    localparam logic [31:0] MARKER_INST = 32'h0030_2013;

    // Comparator FSM states; IDLE encodes as 0 so a reset state reads as 0.
    typedef enum logic [1:0] {
        CDC_IDLE  = 2'd0,
        CDC_TRACK = 2'd1,
        CDC_DRAIN = 2'd2,
        CDC_DONE  = 2'd3
    } cdc_state_e;

    // Probe record layout: DUT instruction in the upper word, variant in the lower.
    function automatic logic [63:0] pack_probe(input logic [31:0] dut_word,
                                               input logic [31:0] vnt_word);
        return {dut_word, vnt_word};
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Small synchronous FIFO buffering one harness's committed instructions.
// A push while full is written only if a pop frees a slot on the same edge;
// the caller is responsible for flagging a dropped push.
module commit_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        empty,
    output logic        full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/commit_diff_checker.sv
// Post-desync commit-stream comparator. Buffers the DUT and variant commit
// streams after the sync monitor drops `sync`, compares them pair by pair,
// captures the first divergence and ends the test on markers, timeout or
// overflow. Build option COMMIT_DIFF_PROBE_EN adds the probe write path.
//
// Commit inputs are valid-only: a harness commit is taken on every edge where
// its valid is high, there is no ready/back-pressure, so a push into a full
// FIFO that is not draining on that edge is lost and reported as overflow.
module commit_diff_checker
    import parafuzz_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sync,
    input  logic        dut_valid,
    input  logic [31:0] dut_inst,
    input  logic        vnt_valid,
    input  logic [31:0] vnt_inst,
    output logic        mismatch,
    output logic [15:0] mismatch_idx,
    output logic [31:0] mismatch_dut_inst,
    output logic [31:0] mismatch_vnt_inst,
    output logic        dut_done,
    output logic        vnt_done,
    output logic        overflow,
    output logic        timeout,
    output logic        done,
    output logic        probe_wen,
    output logic [63:0] probe_write,
    output logic [1:0]  state_dbg
);
    localparam int CNT_W = ($clog2(TIMEOUT) > 13) ? $clog2(TIMEOUT) : 13;

    cdc_state_e       state;
    logic [15:0]      pair_idx;
    logic [CNT_W-1:0] drain_cnt;

    logic [31:0] dut_head, vnt_head;
    logic        dut_empty, vnt_empty, dut_full, vnt_full;
    logic        active, dut_push, vnt_push, pair_pop, dut_pop, vnt_pop;
    logic        dut_mark, vnt_mark, dut_done_nxt, vnt_done_nxt, ovf_evt, pair_diff;

    assign state_dbg = state;

    // Push/pop decisions for the current edge.
    always_comb begin
        active       = (state == CDC_TRACK) || (state == CDC_DRAIN);
        dut_push     = active && dut_valid && !dut_done;
        vnt_push     = active && vnt_valid && !vnt_done;
        pair_pop     = active && !dut_empty && !vnt_empty && !dut_done && !vnt_done;
        dut_pop      = pair_pop || (active && vnt_done && !dut_done && !dut_empty);
        vnt_pop      = pair_pop || (active && dut_done && !vnt_done && !vnt_empty);
        dut_mark     = dut_pop && (dut_head == MARKER_INST);
        vnt_mark     = vnt_pop && (vnt_head == MARKER_INST);
        dut_done_nxt = dut_done || dut_mark;
        vnt_done_nxt = vnt_done || vnt_mark;
        ovf_evt      = (dut_push && dut_full && !dut_pop) ||
                       (vnt_push && vnt_full && !vnt_pop);
        pair_diff    = pair_pop && (dut_head != vnt_head);
    end

    commit_fifo #(.DEPTH(DEPTH)) u_dut_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (dut_push),
        .push_data (dut_inst),
        .pop       (dut_pop),
        .head      (dut_head),
        .empty     (dut_empty),
        .full      (dut_full)
    );

    commit_fifo #(.DEPTH(DEPTH)) u_vnt_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (vnt_push),
        .push_data (vnt_inst),
        .pop       (vnt_pop),
        .head      (vnt_head),
        .empty     (vnt_empty),
        .full      (vnt_full)
    );

    // FSM, pair comparison, first-divergence capture and sticky status.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= CDC_IDLE;
            pair_idx          <= '0;
            drain_cnt         <= '0;
            mismatch          <= 1'b0;
            mismatch_idx      <= '0;
            mismatch_dut_inst <= '0;
            mismatch_vnt_inst <= '0;
            dut_done          <= 1'b0;
            vnt_done          <= 1'b0;
            overflow          <= 1'b0;
            timeout           <= 1'b0;
            done              <= 1'b0;
        end else begin
            case (state)
                CDC_IDLE: begin
                    if (!sync) state <= CDC_TRACK;
                end
                CDC_TRACK, CDC_DRAIN: begin
                    if (dut_mark) dut_done <= 1'b1;
                    if (vnt_mark) vnt_done <= 1'b1;
                    if (pair_pop && (pair_idx != 16'hFFFF)) pair_idx <= pair_idx + 16'd1;
                    if (pair_diff && !mismatch) begin
                        mismatch          <= 1'b1;
                        mismatch_idx      <= pair_idx;
                        mismatch_dut_inst <= dut_head;
                        mismatch_vnt_inst <= vnt_head;
                    end
                    // Overflow beats completion, completion beats timeout.
                    if (ovf_evt) begin
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        state    <= CDC_DONE;
                    end else if (dut_done_nxt && vnt_done_nxt) begin
                        done  <= 1'b1;
                        state <= CDC_DONE;
                    end else if (state == CDC_TRACK) begin
                        if (dut_done_nxt || vnt_done_nxt) begin
                            drain_cnt <= '0;
                            state     <= CDC_DRAIN;
                        end
                    end else if (drain_cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= CDC_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                default: state <= CDC_DONE;
            endcase
        end
    end

`ifdef COMMIT_DIFF_PROBE_EN
    logic mismatch_q;

    // One-cycle probe strobe on the cycle after mismatch first rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mismatch_q <= 1'b0;
            probe_wen  <= 1'b0;
        end else begin
            mismatch_q <= mismatch;
            probe_wen  <= mismatch && !mismatch_q;
        end
    end

    assign probe_write = pack_probe(mismatch_dut_inst, mismatch_vnt_inst);
`else
    assign probe_wen   = 1'b0;
    assign probe_write = '0;
`endif

endmodule
